// File: rtl/note_label_seq_pkg.sv
// Character codes, label record and semitone tables shared by the note-label sequencer.
// Codes are 6-bit tcgrom indices; the sequencer shifts them up by the row width.
package note_text_pkg;

    localparam logic [5:0] CH_SPACE  = 6'h20;
    localparam logic [5:0] CH_SHARP  = 6'h23;
    localparam logic [5:0] CH_R      = 6'h12;
    localparam logic [5:0] CH_A      = 6'h01;
    localparam logic [5:0] CH_B      = 6'h02;
    localparam logic [5:0] CH_C      = 6'h03;
    localparam logic [5:0] CH_D      = 6'h04;
    localparam logic [5:0] CH_E      = 6'h05;
    localparam logic [5:0] CH_F      = 6'h06;
    localparam logic [5:0] CH_G      = 6'h07;
    localparam logic [5:0] CH_DIGIT0 = 6'h30;

    localparam logic [1:0] POS_LAST = 2'd2;

    typedef struct packed {
        logic [5:0] oct;
        logic [5:0] letter;
        logic [5:0] acc;
    } note_label_t;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } seq_state_t;

    // Semitone 0 is A, counting upward.
    function automatic logic [5:0] semi_letter(input logic [3:0] s);
        logic [5:0] r;
        case (s)
            4'd0, 4'd1:  r = CH_A;
            4'd2:        r = CH_B;
            4'd3, 4'd4:  r = CH_C;
            4'd5, 4'd6:  r = CH_D;
            4'd7:        r = CH_E;
            4'd8, 4'd9:  r = CH_F;
            default:     r = CH_G;
        endcase
        return r;
    endfunction

    function automatic logic semi_sharp(input logic [3:0] s);
        logic r;
        case (s)
            4'd1, 4'd4, 4'd6, 4'd9, 4'd11: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/note_label_seq_if.sv
// Character beat link from the sequencer to the text writer (valid/ready).
// master drives the beat, slave returns ready.
interface note_label_seq_if #(
    parameter int CH_W   = 2,
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] char_addr;
    logic [CH_W-1:0]   char_ch;
    logic [1:0]        char_pos;
    logic              char_last;
    logic              char_valid;
    logic              char_ready;

    modport master (
        output char_addr, char_ch, char_pos, char_last, char_valid,
        input  char_ready
    );

    modport slave (
        input  char_addr, char_ch, char_pos, char_last, char_valid,
        output char_ready
    );
endinterface

// File: rtl/note_label_seq_decode.sv
// Combinational note index -> 3-char label; octave/semitone found by a compare chain against multiples of 12.
// Zero latency, no flow control.
module note_char_decode
    import note_text_pkg::*;
#(
    parameter int IDX_W   = 6,
    parameter int MAX_IDX = 63
) (
    input  logic [IDX_W-1:0] idx_i,
    output note_label_t      label_o
);

    localparam int CW = (IDX_W > 7) ? IDX_W : 7;

    logic [CW-1:0] m;
    logic [3:0]    oct;
    logic [3:0]    semi;

    always_comb begin
        m    = CW'(idx_i) - CW'(1);
        oct  = 4'd1;
        semi = 4'(m);
        for (int k = 1; k < 9; k++) begin
            if (m >= CW'(12 * k)) begin
                oct  = 4'(k + 1);
                semi = 4'(m - CW'(12 * k));
            end
        end

        label_o = '{oct: CH_SPACE, letter: CH_SPACE, acc: CH_SPACE};
        if (idx_i == '0) begin
            label_o.oct = CH_R;
        end else if (32'(idx_i) <= 32'(MAX_IDX)) begin
            label_o.oct    = CH_DIGIT0 + 6'(oct);
            label_o.letter = semi_letter(semi);
            label_o.acc    = semi_sharp(semi) ? CH_SHARP : CH_SPACE;
        end
    end

endmodule

// File: rtl/note_label_seq.sv
// Snapshots all channel notes and streams 3 tcgrom addresses per channel; first beat 1 cycle after trigger.
// Beats are registered and held while valid && !ready; start is ignored while a frame is in flight.
module note_label_seq
    import note_text_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int IDX_W        = 6,
    parameter int MAX_IDX      = 63,
    parameter int ROW_W        = 3,
    parameter int AUTO_REFRESH = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*IDX_W-1:0] note_idx,
    input  logic                    start,
    note_label_seq_if.master        char_if,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_W = 6 + ROW_W;

    seq_state_t              state_q, state_d;
    logic [NUM_CH*IDX_W-1:0] snap_q, snap_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [1:0]              pos_q, pos_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic                    pending_q, pending_d;

    logic                    mismatch, trigger, fire;
    logic [CH_W-1:0]         nxt_ch;
    logic [1:0]              nxt_pos;
    logic [NUM_CH*IDX_W-1:0] src;
    logic [IDX_W-1:0]        dec_idx;
    note_label_t             label;
    logic [5:0]              code_sel;

    assign mismatch = (note_idx != snap_q);
    assign trigger  = (state_q == ST_IDLE) &&
                      (start || ((AUTO_REFRESH != 0) && (pending_q || mismatch)));
    assign fire     = (state_q == ST_EMIT) && valid_q && char_if.char_ready;

    // The beat to load next: beat 0 from live inputs on a trigger, else the successor from the snapshot.
    always_comb begin
        nxt_ch  = '0;
        nxt_pos = 2'd0;
        if (state_q == ST_EMIT) begin
            if (pos_q == POS_LAST) begin
                nxt_ch = ch_q + CH_W'(1);
            end else begin
                nxt_ch  = ch_q;
                nxt_pos = pos_q + 2'd1;
            end
        end
    end

    assign src = (state_q == ST_IDLE) ? note_idx : snap_q;

    always_comb begin
        dec_idx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (nxt_ch == CH_W'(c)) begin
                dec_idx = src[c*IDX_W +: IDX_W];
            end
        end
    end

    note_char_decode #(
        .IDX_W   (IDX_W),
        .MAX_IDX (MAX_IDX)
    ) u_decode (
        .idx_i   (dec_idx),
        .label_o (label)
    );

    always_comb begin
        case (nxt_pos)
            2'd0:    code_sel = label.oct;
            2'd1:    code_sel = label.letter;
            default: code_sel = label.acc;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        ch_d      = ch_q;
        pos_d     = pos_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        pending_d = pending_q;

        if (trigger) begin
            pending_d = 1'b0;
        end else if ((AUTO_REFRESH != 0) && (state_q == ST_EMIT) && mismatch) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_EMIT;
                    snap_d  = note_idx;
                    ch_d    = nxt_ch;
                    pos_d   = nxt_pos;
                    addr_d  = ADDR_W'(code_sel) << ROW_W;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            ST_EMIT: begin
                if (fire) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        ch_d   = nxt_ch;
                        pos_d  = nxt_pos;
                        addr_d = ADDR_W'(code_sel) << ROW_W;
                        last_d = (nxt_ch == CH_W'(NUM_CH - 1)) && (nxt_pos == POS_LAST);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            snap_q    <= '0;
            ch_q      <= '0;
            pos_q     <= 2'd0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            ch_q      <= ch_d;
            pos_q     <= pos_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
            pending_q <= pending_d;
        end
    end

    assign char_if.char_addr  = addr_q;
    assign char_if.char_ch    = ch_q;
    assign char_if.char_pos   = pos_q;
    assign char_if.char_last  = last_q;
    assign char_if.char_valid = valid_q;
    assign busy               = (state_q == ST_EMIT);
    assign frame_done         = done_q;

endmodule
